// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Function : Single-port block-RAM controller with post-reset three-pass
//             BIST (pattern write, read/compare, clear) and busy handshake.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          BIST_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic                  bist_err_inj,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rd_valid,
    output logic                  bist_done,
    output logic                  bist_fail
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]         CNT_LAST = CW'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] INJ_ONE  = DATA_WIDTH'(1);

    typedef enum logic [7:0] {
        S_RESET    = 8'b0000_0001,
        S_BIST_WR  = 8'b0000_0010,
        S_BIST_RD  = 8'b0000_0100,
        S_BIST_CLR = 8'b0000_1000,
        S_IDLE     = 8'b0001_0000,
        S_READ     = 8'b0010_0000,
        S_WRITE    = 8'b0100_0000,
        S_FAIL     = 8'b1000_0000
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   exp_q, exp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    bist_done_q, bist_done_d;
    logic                    bist_fail_q, bist_fail_d;

    logic [ADDR_WIDTH-1:0]   cnt_lo;
    logic [DATA_WIDTH-1:0]   pat;
    logic [DATA_WIDTH-1:0]   cmp_word;
    logic                    ram_we, ram_re;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   ram_rdata_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign cnt_lo = cnt_q[ADDR_WIDTH-1:0];

    // BIST pattern is the inverted address, fitted to the word width
    generate
        if (DATA_WIDTH > ADDR_WIDTH) begin : g_pat_pad
            assign pat = ~{{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, cnt_lo};
        end else begin : g_pat_trunc
            assign pat = ~cnt_lo[DATA_WIDTH-1:0];
        end
    endgenerate

    assign cmp_word = ram_rdata_q ^ (bist_err_inj ? INJ_ONE : '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        exp_d       = exp_q;
        rdata_d     = rdata_q;
        rd_valid_d  = 1'b0;
        bist_fail_d = bist_fail_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = addr_q;
        ram_wdata   = wdata_q;
        busy        = 1'b1;

        case (state_q)
            S_RESET: begin
                cnt_d   = '0;
                state_d = BIST_EN ? S_BIST_WR : S_IDLE;
            end
            S_BIST_WR: begin
                ram_we    = 1'b1;
                ram_addr  = cnt_lo;
                ram_wdata = pat;
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_BIST_RD;
                end
            end
            S_BIST_RD: begin
                // Read issued at count a is checked at count a+1; count DEPTH only checks
                if (!cnt_q[ADDR_WIDTH]) begin
                    ram_re   = 1'b1;
                    ram_addr = cnt_lo;
                    exp_d    = pat;
                end
                if ((cnt_q != '0) && (cmp_word != exp_q)) begin
                    bist_fail_d = 1'b1;
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q[ADDR_WIDTH]) begin
                    cnt_d   = '0;
                    state_d = bist_fail_d ? S_FAIL : S_BIST_CLR;
                end
            end
            S_BIST_CLR: begin
                ram_we    = 1'b1;
                ram_addr  = cnt_lo;
                ram_wdata = '0;
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                busy = 1'b0;
                if (write_en) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = S_WRITE;
                end else if (read_en) begin
                    // RAM is addressed straight from the bus so data lands one edge later
                    addr_d   = addr;
                    ram_re   = 1'b1;
                    ram_addr = addr;
                    state_d  = S_READ;
                end
            end
            S_WRITE: begin
                ram_we  = 1'b1;
                state_d = S_IDLE;
            end
            S_READ: begin
                rdata_d    = ram_rdata_q;
                rd_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        bist_done_d = bist_done_q | (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_RESET;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            exp_q       <= '0;
            rdata_q     <= '0;
            rd_valid_q  <= 1'b0;
            bist_done_q <= 1'b0;
            bist_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            exp_q       <= exp_d;
            rdata_q     <= rdata_d;
            rd_valid_q  <= rd_valid_d;
            bist_done_q <= bist_done_d;
            bist_fail_q <= bist_fail_d;
        end
    end

    // Storage carries no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (reset && ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        if (reset && ram_re) begin
            ram_rdata_q <= mem[ram_addr];
        end
    end

    assign rdata     = rdata_q;
    assign rd_valid  = rd_valid_q;
    assign bist_done = bist_done_q;
    assign bist_fail = bist_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl
//  Function : Directed self-checking bench for mem_ctrl (BIST and no-BIST builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  addr = '0;
    logic [7:0]  wdata = '0;
    logic        read_en = 1'b0, write_en = 1'b0, err_inj = 1'b0;
    logic        busy, rd_valid, bist_done, bist_fail;
    logic [7:0]  rdata;

    logic        reset_b = 1'b0;
    logic [5:0]  addr_b = '0;
    logic [15:0] wdata_b = '0;
    logic        read_en_b = 1'b0, write_en_b = 1'b0;
    logic        busy_b, rd_valid_b, bist_done_b, bist_fail_b;
    logic [15:0] rdata_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .BIST_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .read_en(read_en), .write_en(write_en), .bist_err_inj(err_inj),
        .busy(busy), .rdata(rdata), .rd_valid(rd_valid),
        .bist_done(bist_done), .bist_fail(bist_fail)
    );

    mem_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .BIST_EN(1'b0)) u_dut_nb (
        .clk(clk), .reset(reset_b), .addr(addr_b), .wdata(wdata_b),
        .read_en(read_en_b), .write_en(write_en_b), .bist_err_inj(1'b0),
        .busy(busy_b), .rdata(rdata_b), .rd_valid(rd_valid_b),
        .bist_done(bist_done_b), .bist_fail(bist_fail_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        step;
        step;
        reset = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int edges = 0;
        bit early = 1'b0;
        bit rv = 1'b0;
        while (busy === 1'b1 && edges < 300) begin
            step;
            edges++;
            if (busy && bist_done) early = 1'b1;
            if (rd_valid) rv = 1'b1;
        end
        check({tag, "_ready_edge"}, edges, 50);
        check({tag, "_done"}, bist_done, 1);
        check({tag, "_nofail"}, bist_fail, 0);
        check({tag, "_done_early"}, early, 0);
        check({tag, "_rdv_in_bist"}, rv, 0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        addr = a; wdata = d; write_en = 1'b1;
        step;
        write_en = 1'b0;
        check("wr_busy", busy, 1);
        step;
        check("wr_idle", busy, 0);
    endtask

    task automatic do_read(input logic [3:0] a, output logic [7:0] d);
        addr = a; read_en = 1'b1;
        step;
        read_en = 1'b0;
        check("rd_busy", busy, 1);
        step;
        check("rd_valid", rd_valid, 1);
        check("rd_idle", busy, 0);
        d = rdata;
    endtask

    initial begin
        logic [7:0] d;
        bit bad;

        // No-BIST build: 64 x 16, ready after the first edge
        step;
        step;
        reset_b = 1'b1;
        step;
        check("nb_busy", busy_b, 0);
        check("nb_done", bist_done_b, 1);
        check("nb_fail", bist_fail_b, 0);
        addr_b = 6'd63; wdata_b = 16'hBEEF; write_en_b = 1'b1;
        step;
        write_en_b = 1'b0;
        step;
        read_en_b = 1'b1;
        step;
        read_en_b = 1'b0;
        step;
        check("nb_rd_valid", rd_valid_b, 1);
        check("nb_rdata", rdata_b, 16'hBEEF);

        // BIST build: reset state, timing to ready, cleared memory
        do_reset;
        check("rst_busy", busy, 1);
        check("rst_rdata", rdata, 0);
        check("rst_done", bist_done, 0);
        wait_ready("bist1");
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), d);
            check("clear_word", d, 0);
        end

        // Write then read back, rd_valid pulse width, rdata hold
        do_write(4'd3, 8'h5A);
        do_read(4'd3, d);
        check("raw_data", d, 8'h5A);
        step;
        check("rdv_one_cycle", rd_valid, 0);
        check("rdata_hold", rdata, 8'h5A);

        // Simultaneous read+write: write wins, read dropped
        addr = 4'd7; wdata = 8'hC3; read_en = 1'b1; write_en = 1'b1;
        step;
        read_en = 1'b0; write_en = 1'b0;
        check("both_busy", busy, 1);
        step;
        check("both_no_rdv", rd_valid, 0);
        step;
        check("both_no_rdv2", rd_valid, 0);
        // Read request while busy is ignored
        addr = 4'd9; wdata = 8'h11; write_en = 1'b1;
        step;
        write_en = 1'b0;
        read_en = 1'b1;
        step;
        read_en = 1'b0;
        step;
        check("busy_rd_ignored", rd_valid, 0);
        do_read(4'd7, d);
        check("both_wrote", d, 8'hC3);
        do_read(4'd9, d);
        check("wr9", d, 8'h11);

        // Reset in the middle of a read
        addr = 4'd3; read_en = 1'b1;
        step;
        read_en = 1'b0;
        reset = 1'b0;
        step;
        check("midrd_busy", busy, 1);
        check("midrd_rdv", rd_valid, 0);
        check("midrd_rdata", rdata, 0);
        check("midrd_done", bist_done, 0);
        step;
        reset = 1'b1;
        // Reset again inside the read/compare pass
        repeat (25) step;
        reset = 1'b0;
        step;
        check("midbist_busy", busy, 1);
        check("midbist_rdv", rd_valid, 0);
        check("midbist_rdata", rdata, 0);
        check("midbist_done", bist_done, 0);
        reset = 1'b1;
        wait_ready("bist2");
        do_read(4'd3, d);
        check("reclear", d, 0);

        // Injected miscompare drives the controller into FAIL
        err_inj = 1'b1;
        do_reset;
        repeat (18) step;
        check("inj_fail_pre", bist_fail, 0);
        step;
        check("inj_fail_rise", bist_fail, 1);
        repeat (15) step;
        err_inj = 1'b0;
        addr = 4'd1; wdata = 8'hFF; write_en = 1'b1;
        bad = 1'b0;
        repeat (110) begin
            step;
            if (!busy || bist_done || rd_valid || !bist_fail) bad = 1'b1;
        end
        write_en = 1'b0;
        check("fail_sticky", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
